serial_parity_rx: RTL

Serial frame receiver that sits directly upstream of the 9-bit parity generator/checker. It samples a one-wire serial line on a bit-rate strobe and deserializes each frame of start bit, 8 data bits, 1 parity bit and stop bit. It presents the 9-bit word (parity bit in the MSB) on a parallel bus with a one-cycle valid pulse, for the checker to consume. An optional built-in parity check flags bad words without waiting on the downstream checker.

---
 rtl/serial_parity_rx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
//
// Receives one frame on a one-wire serial line and hands the 9-bit word to a
// downstream parity checker. A frame is a start bit, 8 data bits, a parity bit
// and a stop bit. The line is sampled only on clocks where the bit-rate strobe
// is high, and bits arrive LSB first.
//
// Optional feature: define SERIAL_PARITY_RX_CHECK_EN to build the local parity
// check. Without it, parity_err is tied low and no parity logic exists.
//
// Parameters:
//   PARITY_ODD  expected parity of the 9-bit word (0 = even, 1 = odd)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   bit_en      bit-rate sample strobe, one clk wide
//   rx          serial line, idle high
//   word_out    last good frame: [7:0] data, [8] parity bit
//   word_valid  one-cycle pulse when word_out is updated
//   parity_err  parity mismatch, qualified by word_valid
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high while a frame is in progress
// -----------------------------------------------------------------------------
module serial_parity_rx #(
   parameter logic PARITY_ODD = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_en,
   input  logic       rx,
   output logic [8:0] word_out,
   output logic       word_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd1;
   localparam logic [1:0] STOP = 2'd2;

   logic [1:0] state;
   logic [3:0] cnt;
   logic [8:0] shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         shreg      <= 9'h000;
         word_out   <= 9'h000;
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         // Status outputs are pulses; they drop on every cycle by default.
         word_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (bit_en) begin
            case (state)
               IDLE: begin
                  if (!rx) begin
                     state <= DATA;
                     cnt   <= 4'd0;
                  end
               end
               DATA: begin
                  // Right shift: the first bit received ends up in [0].
                  shreg <= {rx, shreg[8:1]};
                  if (cnt == 4'd8) begin
                     cnt   <= 4'd0;
                     state <= STOP;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               STOP: begin
                  if (rx) begin
                     word_out   <= shreg;
                     word_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  cnt   <= 4'd0;
               end
            endcase
         end
      end
   end

`ifdef SERIAL_PARITY_RX_CHECK_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= 1'b0;
         if (bit_en && (state == STOP) && rx) begin
            parity_q <= (^shreg) ^ PARITY_ODD;
         end
      end
   end

   assign parity_err = parity_q;
`else
   // Checking is left to the downstream checker; the parameter is unused here.
   logic unused_parity_odd;
   assign unused_parity_odd = PARITY_ODD;
   assign parity_err        = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule
